// File: rtl/dlx_pkg.sv
// Shared DLX definitions: instruction width, the NOP encoding and the
// fetch FSM state encoding.
package dlx_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk_i, reset_i     - clock, synchronous active-high reset
//   load_i             - capture instr_i/pc_i and mark the entry live
//   hold_i             - freeze the register (blocks load_i)
//   squash_i           - kill the entry: valid cleared, instr forced to NOP
//   instr_i, pc_i      - fetched word and the address it came from
//   valid_o, instr_o, pc_o, npc_o - registered entry (npc_o = pc_o + 4)
// Priority: reset > squash > hold > load. pc/npc keep their value on squash.
module ifid_reg
  import dlx_pkg::*;
#(
  parameter logic [31:0] ResetPc = 32'h0000_0000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               hold_i,
  input  logic               squash_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o,
  output logic [31:0]        npc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_q;
  logic [31:0]        npc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= ResetPc;
      npc_q   <= ResetPc + 32'd4;
    end else if (squash_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i && !hold_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
      npc_q   <= pc_i + 32'd4;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign npc_o   = npc_q;

endmodule

// File: rtl/fetch_unit.sv
// DLX instruction fetch stage: PC register, IDLE/FETCH/FAULT control FSM and
// the IF/ID register feeding decode.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   run                         - fetch enable
//   stall                       - decode cannot accept; hold PC and IF/ID
//   redirect_valid/_target      - branch/jump target from a later stage
//   imem_cs/oe/we/addr/dout     - instruction memory (combinational read)
//   ifid_valid/instr/pc/npc     - IF/ID register contents
//   fetch_fault                 - a misaligned redirect was taken
//   fetch_count                 - instructions delivered into IF/ID
module fetch_unit
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               imem_cs,
  output logic               imem_oe,
  output logic               imem_we,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_dout,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [31:0]        ifid_pc,
  output logic [31:0]        ifid_npc,
  output logic               fetch_fault,
  output logic [31:0]        fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         load;
  logic         squash;
  logic         redirect_misaligned;

  assign redirect_misaligned = (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    squash  = 1'b0;
    if (redirect_valid) begin
      // Redirect wins over stall and run; the word fetched this cycle is dropped.
      pc_d   = redirect_target;
      squash = 1'b1;
      if (redirect_misaligned) begin
        state_d = StFault;
      end else if (state_q == StFetch) begin
        state_d = StFetch;
      end else begin
        state_d = run ? StFetch : StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // Drain the last live entry once decode has taken it.
          squash  = !stall;
          state_d = run ? StFetch : StIdle;
        end
        StFetch: begin
          if (!stall) begin
            load = 1'b1;
            pc_d = pc_q + 32'd4;
          end
          if (!run) begin
            state_d = StIdle;
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
    count_d = count_q + {31'b0, load};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  ifid_reg #(
    .ResetPc(RESET_PC)
  ) u_ifid_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (load),
    .hold_i  (stall),
    .squash_i(squash),
    .instr_i (imem_dout),
    .pc_i    (pc_q),
    .valid_o (ifid_valid),
    .instr_o (ifid_instr),
    .pc_o    (ifid_pc),
    .npc_o   (ifid_npc)
  );

  assign imem_cs     = (state_q == StFetch);
  assign imem_oe     = (state_q == StFetch);
  assign imem_we     = 1'b0;
  assign imem_addr   = pc_q;
  assign fetch_fault = (state_q == StFault);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_cs, imem_oe, imem_we;
  logic [31:0] imem_addr, imem_dout;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc, ifid_npc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2001_AAAA;
    if (a == 32'h4) return 32'h8003_0080;
    return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
  endfunction

  assign imem_dout = mem_word(imem_addr);

  fetch_unit #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_cs        (imem_cs),
    .imem_oe        (imem_oe),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_npc       (ifid_npc),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, want %h", name, idx, act, exp);
    end
  endtask

  // Directed vectors: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        rst, rn, stl, rv;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic        e_cs, e_valid;
    logic [31:0] e_instr, e_pc, e_npc;
    logic        e_fault;
    logic [31:0] e_count;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl[NVEC];

  function automatic vec_t mk(input logic rst, rn, stl, rv, input logic [31:0] tgt,
                              input logic [31:0] e_addr, input logic e_cs, e_valid,
                              input logic [31:0] e_instr, e_pc, e_npc,
                              input logic e_fault, input logic [31:0] e_count);
    vec_t v;
    v.rst = rst; v.rn = rn; v.stl = stl; v.rv = rv; v.tgt = tgt;
    v.e_addr = e_addr; v.e_cs = e_cs; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_pc = e_pc; v.e_npc = e_npc; v.e_fault = e_fault; v.e_count = e_count;
    return v;
  endfunction

  // Reference model state, derived from the behavioural rules of the fetch stage.
  logic        m_fetching, m_faulted, m_valid;
  logic [31:0] m_pc, m_instr, m_ipc, m_inpc, m_count;

  task automatic model_step();
    if (reset) begin
      m_pc = 32'h0; m_fetching = 1'b0; m_faulted = 1'b0; m_valid = 1'b0;
      m_instr = 32'h0; m_ipc = 32'h0; m_inpc = 32'h4; m_count = 32'h0;
    end else if (redirect_valid) begin
      m_pc = redirect_target; m_valid = 1'b0; m_instr = 32'h0;
      if (redirect_target % 4 != 0) begin
        m_faulted = 1'b1; m_fetching = 1'b0;
      end else begin
        m_fetching = m_fetching || run;
        m_faulted = 1'b0;
      end
    end else if (m_faulted) begin
      // nothing moves while faulted
    end else if (m_fetching) begin
      if (!stall) begin
        m_ipc = m_pc; m_inpc = m_pc + 32'd4; m_instr = mem_word(m_pc);
        m_valid = 1'b1; m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
      end
      m_fetching = run;
    end else begin
      if (!stall) begin
        m_valid = 1'b0; m_instr = 32'h0;
      end
      m_fetching = run;
    end
  endtask

  initial begin
    tbl[0]  = mk(1, 1, 0, 1, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 32'h4, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 32'h4, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 32'h0, 32'h4, 1, 1, 32'h2001_AAAA, 32'h0, 32'h4, 0, 1);
    tbl[3]  = mk(0, 1, 0, 0, 32'h0, 32'h8, 1, 1, 32'h8003_0080, 32'h4, 32'h8, 0, 2);
    tbl[4]  = mk(0, 1, 1, 0, 32'h0, 32'h8, 1, 1, 32'h8003_0080, 32'h4, 32'h8, 0, 2);
    tbl[5]  = mk(0, 1, 1, 0, 32'h0, 32'h8, 1, 1, 32'h8003_0080, 32'h4, 32'h8, 0, 2);
    tbl[6]  = mk(0, 1, 1, 0, 32'h0, 32'h8, 1, 1, 32'h8003_0080, 32'h4, 32'h8, 0, 2);
    tbl[7]  = mk(0, 1, 1, 1, 32'h80, 32'h80, 1, 0, 32'h0, 32'h4, 32'h8, 0, 2);
    tbl[8]  = mk(0, 1, 0, 0, 32'h0, 32'h84, 1, 1, mem_word(32'h80), 32'h80, 32'h84, 0, 3);
    tbl[9]  = mk(0, 1, 0, 1, 32'h82, 32'h82, 0, 0, 32'h0, 32'h80, 32'h84, 1, 3);
    tbl[10] = mk(0, 1, 0, 0, 32'h0, 32'h82, 0, 0, 32'h0, 32'h80, 32'h84, 1, 3);
    tbl[11] = mk(0, 1, 0, 1, 32'h40, 32'h40, 1, 0, 32'h0, 32'h80, 32'h84, 0, 3);
    tbl[12] = mk(0, 1, 0, 0, 32'h0, 32'h44, 1, 1, mem_word(32'h40), 32'h40, 32'h44, 0, 4);
    tbl[13] = mk(0, 1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 32'h0, 32'h40, 32'h44, 0, 4);
    tbl[14] = mk(0, 1, 0, 0, 32'h0, 32'h0, 1, 1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC,
                 32'h0, 0, 5);
    tbl[15] = mk(1, 1, 1, 1, 32'h100, 32'h0, 0, 0, 32'h0, 32'h0, 32'h4, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h4, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      reset = tbl[i].rst; run = tbl[i].rn; stall = tbl[i].stl;
      redirect_valid = tbl[i].rv; redirect_target = tbl[i].tgt;
      @(posedge clk);
      #1;
      chk("imem_addr", i, imem_addr, tbl[i].e_addr);
      chk("imem_cs", i, {31'b0, imem_cs}, {31'b0, tbl[i].e_cs});
      chk("imem_oe", i, {31'b0, imem_oe}, {31'b0, tbl[i].e_cs});
      chk("imem_we", i, {31'b0, imem_we}, 32'h0);
      chk("ifid_valid", i, {31'b0, ifid_valid}, {31'b0, tbl[i].e_valid});
      chk("ifid_instr", i, ifid_instr, tbl[i].e_instr);
      chk("ifid_pc", i, ifid_pc, tbl[i].e_pc);
      chk("ifid_npc", i, ifid_npc, tbl[i].e_npc);
      chk("fetch_fault", i, {31'b0, fetch_fault}, {31'b0, tbl[i].e_fault});
      chk("fetch_count", i, fetch_count, tbl[i].e_count);
    end

    // Randomized run against the reference model; first cycle forces reset.
    for (int c = 0; c < 2000; c++) begin
      reset = (c == 0) || ($urandom_range(0, 99) == 0);
      run = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) redirect_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else redirect_target = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) redirect_target[1:0] = 2'($urandom_range(1, 3));
      model_step();
      @(posedge clk);
      #1;
      chk("rnd imem_addr", c, imem_addr, m_pc);
      chk("rnd imem_cs", c, {31'b0, imem_cs}, {31'b0, m_fetching});
      chk("rnd imem_oe", c, {31'b0, imem_oe}, {31'b0, m_fetching});
      chk("rnd ifid_valid", c, {31'b0, ifid_valid}, {31'b0, m_valid});
      chk("rnd ifid_instr", c, ifid_instr, m_instr);
      chk("rnd ifid_pc", c, ifid_pc, m_ipc);
      chk("rnd ifid_npc", c, ifid_npc, m_inpc);
      chk("rnd fetch_fault", c, {31'b0, fetch_fault}, {31'b0, m_faulted});
      chk("rnd fetch_count", c, fetch_count, m_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the byte address fetched first after reset.
REQ-002 SHALL have port clk, input, 1, meaning the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, meaning the reset; it is synchronous and active-high.
REQ-004 SHALL have port run, input, 1, meaning fetch enable; 0 idles the unit.
REQ-005 SHALL have port stall, input, 1, meaning decode cannot accept; hold PC and IF/ID.
REQ-006 SHALL have port redirect_valid, input, 1, meaning a branch/jump target from a later stage.
REQ-007 SHALL have port redirect_target, input, 32, meaning the byte address of the next fetch.
REQ-008 SHALL have port imem_cs, output, 1, meaning instruction memory chip select.
REQ-009 SHALL have port imem_oe, output, 1, meaning instruction memory output enable.
REQ-010 SHALL have port imem_we, output, 1, meaning instruction memory write enable; it is constant 0.
REQ-011 SHALL have port imem_addr, output, 32, meaning the fetch byte address; it equals the current PC.
REQ-012 SHALL have port imem_dout, input, 32, meaning the instruction word, valid combinationally in the same cycle as imem_addr.
REQ-013 SHALL have port ifid_valid, output, 1, meaning the IF/ID register holds a live instruction.
REQ-014 SHALL have port ifid_instr, output, 32, meaning the fetched instruction word.
REQ-015 SHALL have port ifid_pc, output, 32, meaning the address ifid_instr was fetched from.
REQ-016 SHALL have port ifid_npc, output, 32, meaning ifid_pc+4.
REQ-017 SHALL have port fetch_fault, output, 1, meaning a misaligned redirect was taken.
REQ-018 SHALL have port fetch_count, output, 32, meaning the number of instructions delivered into IF/ID.

Function
REQ-019 SHALL implement an FSM with states IDLE, FETCH and FAULT, registered on clk.
REQ-020 SHALL transition IDLE->FETCH when run=1; FETCH->IDLE when run=0 and no redirect is present; FAULT exits only on reset or an aligned redirect.
REQ-021 SHALL drive imem_cs=imem_oe=1 only in FETCH.
REQ-022 In FETCH with stall=0 and redirect_valid=0, SHALL at the edge load ifid_instr<=imem_dout, ifid_pc<=PC, ifid_npc<=PC+4, ifid_valid<=1 and PC<=PC+4 (one-cycle latency).
REQ-023 In FETCH with stall=1 and redirect_valid=0, SHALL hold PC and all ifid_* outputs unchanged.
REQ-024 redirect_valid SHALL take priority over stall and run in every state: at the edge PC<=redirect_target, ifid_valid<=0 and ifid_instr<=NOP_INSTR, squashing the word fetched that cycle.
REQ-025 Taking an aligned redirect from IDLE or FAULT SHALL enter FETCH if run=1, otherwise IDLE.
REQ-026 A redirect_target with bits [1:0]!=0 SHALL enter FAULT with fetch_fault=1, ifid_valid=0 and PC<=redirect_target; no fetch is performed while in FAULT.
REQ-027 In IDLE, ifid_* SHALL hold their values except that ifid_valid<=0 once decode is not stalling.
REQ-028 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 yields 32'h0000_0000 with no flag.
REQ-029 fetch_count SHALL increment by 1 on each REQ-022 load and wrap modulo 2^32.
REQ-030 When ifid_valid=0, ifid_instr SHALL equal NOP_INSTR.

Reset
REQ-031 When reset=1 at a clk edge, the unit SHALL set state=IDLE, PC=RESET_PC, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=RESET_PC, ifid_npc=RESET_PC+4, fetch_fault=0 and fetch_count=0.
REQ-032 Reset SHALL override redirect, stall and run, including in the middle of an operation.
REQ-033 In the cycle after reset with run=1, the unit SHALL be in FETCH, and the first IF/ID load SHALL occur at the following edge.

Structure
REQ-034 The constants NOP_INSTR (32'h0000_0000), INSTR_W (32) and the fetch FSM state encoding SHALL reside in the shared dlx_pkg package.
REQ-035 The IF/ID register SHALL be one sub-module, ifid_reg, with load, hold and squash controls; the PC and FSM SHALL be inline.

Verification
REQ-036 The bench SHALL cover: memory returns 0x2001AAAA at 0x0 and 0x8003_0080 at 0x4, run=1 after reset -> ifid_pc=0x0 then 0x4, ifid_instr matching, fetch_count=2.
REQ-037 The bench SHALL cover: stall=1 for 3 cycles at PC=0x8 -> imem_addr stays 0x8, ifid_* frozen, fetch_count unchanged.
REQ-038 The bench SHALL cover: redirect_valid=1 with target 0x80 together with stall=1 -> next cycle imem_addr=0x80, ifid_valid=0, ifid_instr=0.
REQ-039 The bench SHALL cover: redirect to 0x82 -> fetch_fault=1, imem_cs=0; then redirect to 0x40 -> FETCH with fault cleared.
REQ-040 The bench SHALL cover: PC=0xFFFF_FFFC, no stall -> next imem_addr=0x0, ifid_npc=0x0.
REQ-041 The bench SHALL cover: reset asserted mid-stream with redirect_valid=1 -> all REQ-031 values, PC=RESET_PC.
